// File: rtl/dcache_snoop_responder.sv
// dcache_snoop_responder: MSI snoop agent living beside each dcache.
// Looks up snooped blocks, supplies dirty blocks on ccwrite, and issues the
// M->S / M->I / S->I state update strobe. Holds the local cache FSM off via
// snoop_busy while a snoop is in flight.
// Optional feature macro: SNOOP_LINK_EN (invalidating snoops kill a matching
// LL/SC link through link_clear; otherwise link_clear is tied low).
module dcache_snoop_responder #(
    parameter  int SETS = 8,
    parameter  int WAYS = 2,
    localparam int IDXW = $clog2(SETS),
    localparam int WAYW = $clog2(WAYS),
    localparam int TAGW = 32 - IDXW - 3
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   ccwait,
    input  logic                   ccinv,
    input  logic [31:0]            ccsnoopaddr,
    input  logic                   dwait,
    output logic                   ccwrite,
    output logic                   snoop_dWEN,
    output logic [31:0]            snoop_daddr,
    output logic [31:0]            snoop_dstore,
    output logic                   snoop_busy,
    output logic [IDXW-1:0]        arr_idx,
    input  logic [WAYS-1:0]        arr_valid,
    input  logic [WAYS-1:0]        arr_dirty,
    input  logic [WAYS*TAGW-1:0]   arr_tag,
    input  logic [WAYS*64-1:0]     arr_data,
    output logic                   upd_en,
    output logic [WAYW-1:0]        upd_way,
    output logic                   upd_inv,
    input  logic                   link_valid,
    input  logic [31:0]            link_addr,
    output logic                   link_clear
);

    localparam int BLKW = TAGW + IDXW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB0,
        S_WB1,
        S_UPDATE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [BLKW-1:0]   r_blk;        // latched block address (addr[31:3])
    logic              r_inv;
    logic [WAYW-1:0]   r_way;
    logic              r_ccwrite;

    logic [TAGW-1:0]   w_tag;
    logic [IDXW-1:0]   w_idx;
    logic              w_inv_eff;
    logic              w_hit;
    logic              w_hit_dirty;
    logic [WAYW-1:0]   w_hit_way;
    logic [63:0]       w_way_data;
    logic              w_link_evt;
    logic              w_unused;

    assign w_tag     = r_blk[BLKW-1 -: TAGW];
    assign w_idx     = r_blk[IDXW-1:0];
    assign w_inv_eff = r_inv | ccinv;

    assign ccwrite    = r_ccwrite;
    assign snoop_busy = ccwait | (r_state != S_IDLE);

    // Tag compare across ways; the lowest-numbered hitting way wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_dirty = 1'b0;
        w_hit_way   = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!w_hit && arr_valid[i] && (arr_tag[i*TAGW +: TAGW] == w_tag)) begin
                w_hit       = 1'b1;
                w_hit_dirty = arr_dirty[i];
                w_hit_way   = WAYW'(i);
            end
        end
    end

    // Select the block data of the latched way for write-back.
    always_comb begin
        w_way_data = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (r_way == WAYW'(i)) begin
                w_way_data = arr_data[i*64 +: 64];
            end
        end
    end

    // Next-state decode and state-driven outputs.
    always_comb begin
        w_next       = r_state;
        snoop_dWEN   = 1'b0;
        snoop_daddr  = '0;
        snoop_dstore = '0;
        upd_en       = 1'b0;
        upd_way      = '0;
        upd_inv      = 1'b0;
        arr_idx      = '0;
        w_link_evt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ccwait) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                arr_idx    = w_idx;
                w_link_evt = ccwait & w_hit & ~w_hit_dirty & w_inv_eff;
                if (!ccwait)                 w_next = S_IDLE;
                else if (w_hit && w_hit_dirty) w_next = S_WB0;
                else if (w_hit && w_inv_eff)   w_next = S_UPDATE;
                else                         w_next = S_IDLE;
            end
            S_WB0: begin
                arr_idx      = w_idx;
                snoop_dWEN   = 1'b1;
                snoop_daddr  = {r_blk, 3'b000};
                snoop_dstore = w_way_data[31:0];
                if (!ccwait)     w_next = S_IDLE;
                else if (!dwait) w_next = S_WB1;
            end
            S_WB1: begin
                arr_idx      = w_idx;
                snoop_dWEN   = 1'b1;
                snoop_daddr  = {r_blk, 3'b100};
                snoop_dstore = w_way_data[63:32];
                if (!ccwait)     w_next = S_IDLE;
                else if (!dwait) w_next = S_UPDATE;
            end
            S_UPDATE: begin
                arr_idx  = w_idx;
                upd_en   = 1'b1;
                upd_way  = r_way;
                upd_inv  = r_inv;
                // Clean-hit invalidates already pulsed in LOOKUP; only the
                // write-back path (ccwrite still high) pulses here.
                w_link_evt = r_inv & r_ccwrite;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register plus latched snoop address, inv flag, way and ccwrite.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= S_IDLE;
            r_blk     <= '0;
            r_inv     <= 1'b0;
            r_way     <= '0;
            r_ccwrite <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_ccwrite <= 1'b0;
                    if (ccwait) begin
                        r_blk <= ccsnoopaddr[31:3];
                        r_inv <= ccinv;
                    end
                end
                S_LOOKUP: begin
                    r_inv     <= w_inv_eff;
                    r_ccwrite <= ccwait & w_hit & w_hit_dirty;
                    if (ccwait && w_hit) r_way <= w_hit_way;
                end
                S_WB0, S_WB1: begin
                    if (!ccwait) r_ccwrite <= 1'b0;
                end
                default: r_ccwrite <= 1'b0;
            endcase
        end
    end

`ifdef SNOOP_LINK_EN
    assign link_clear = w_link_evt & link_valid & (link_addr[31:3] == r_blk);
    assign w_unused   = ^{ccsnoopaddr[2:0], link_addr[2:0]};
`else
    assign link_clear = 1'b0;
    assign w_unused   = ^{ccsnoopaddr[2:0], link_valid, link_addr, w_link_evt};
`endif

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Self-checking bench for dcache_snoop_responder (SETS=8, WAYS=2).
module tb_dcache_snoop_responder;

    logic         CLK, nRST;
    logic         ccwait, ccinv, dwait;
    logic [31:0]  ccsnoopaddr;
    logic         ccwrite, snoop_dWEN, snoop_busy;
    logic [31:0]  snoop_daddr, snoop_dstore;
    logic [2:0]   arr_idx;
    logic [1:0]   arr_valid, arr_dirty;
    logic [51:0]  arr_tag;
    logic [127:0] arr_data;
    logic         upd_en, upd_way, upd_inv;
    logic         link_valid, link_clear;
    logic [31:0]  link_addr;

    dcache_snoop_responder #(.SETS(8), .WAYS(2)) dut (
        .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .dwait(dwait), .ccwrite(ccwrite),
        .snoop_dWEN(snoop_dWEN), .snoop_daddr(snoop_daddr),
        .snoop_dstore(snoop_dstore), .snoop_busy(snoop_busy),
        .arr_idx(arr_idx), .arr_valid(arr_valid), .arr_dirty(arr_dirty),
        .arr_tag(arr_tag), .arr_data(arr_data), .upd_en(upd_en),
        .upd_way(upd_way), .upd_inv(upd_inv), .link_valid(link_valid),
        .link_addr(link_addr), .link_clear(link_clear)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Tag/state array seen by the DUT.
    logic        m_valid [8][2];
    logic        m_dirty [8][2];
    logic [25:0] m_tag   [8][2];
    logic [31:0] m_d0    [8][2];
    logic [31:0] m_d1    [8][2];

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            arr_valid[w]         = m_valid[arr_idx][w];
            arr_dirty[w]         = m_dirty[arr_idx][w];
            arr_tag[w*26 +: 26]  = m_tag[arr_idx][w];
            arr_data[w*64 +: 64] = {m_d1[arr_idx][w], m_d0[arr_idx][w]};
        end
    end

    typedef struct packed {
        logic        cw;
        logic        wen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic        busy;
        logic [2:0]  idx;
        logic        upd;
        logic        uway;
        logic        uinv;
        logic        lclr;
    } obs_t;

    typedef struct {
        logic        w;
        logic        inv;
        logic [31:0] a;
        logic        dw;
        obs_t        e;
    } cyc_t;

    typedef struct {
        logic [31:0] addr;
        logic        inv;
        int          s0;
        int          s1;
        int          e_cw;
        int          e_upd;
        logic        e_way;
        logic        e_uinv;
        logic [31:0] e_a0;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        int          e_len;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic obs_t sample();
        obs_t o;
        o.cw = ccwrite; o.wen = snoop_dWEN; o.daddr = snoop_daddr;
        o.dstore = snoop_dstore; o.busy = snoop_busy; o.idx = arr_idx;
        o.upd = upd_en; o.uway = upd_way; o.uinv = upd_inv; o.lclr = link_clear;
        return o;
    endfunction

    function automatic obs_t mk(input logic cw, input logic wen, input logic [31:0] da,
                                input logic [31:0] ds, input logic busy, input logic [2:0] ix,
                                input logic up, input logic uw, input logic ui, input logic lc);
        obs_t o;
        o.cw = cw; o.wen = wen; o.daddr = da; o.dstore = ds; o.busy = busy;
        o.idx = ix; o.upd = up; o.uway = uw; o.uinv = ui; o.lclr = lc;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("cw=%0b wen=%0b daddr=%h dstore=%h busy=%0b idx=%0d upd=%0b way=%0b inv=%0b lclr=%0b",
                         o.cw, o.wen, o.daddr, o.dstore, o.busy, o.idx, o.upd, o.uway, o.uinv, o.lclr);
    endfunction

    task automatic chk_obs(input string nm, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got [%s] expected [%s]", nm, fmt(act), fmt(exp));
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // One clock: apply inputs just after the edge, compare at the falling edge.
    task automatic cyc(input logic w, input logic inv, input logic [31:0] a, input logic dw,
                       input string nm, input obs_t e);
        ccwait = w; ccinv = inv; ccsnoopaddr = a; dwait = dw;
        @(negedge CLK);
        chk_obs(nm, sample(), e);
        @(posedge CLK); #1;
    endtask

    // Table-driven snoop: watch events and compare against the table record.
    task automatic run_vec(input int n, input vec_t v);
        int          first_cw = -1;
        int          upd_cnt = 0;
        int          idle_at = -1;
        int          nw;
        logic        got_way = 1'b0, got_inv = 1'b0;
        logic [31:0] wa[$];
        logic [31:0] wd[$];
        obs_t        o;
        for (int c = 0; c < v.e_len + 2; c++) begin
            ccwait = (c < v.e_len); ccinv = v.inv; ccsnoopaddr = v.addr;
            dwait  = ((c >= 2 && c < 2 + v.s0) || (c >= 3 + v.s0 && c < 3 + v.s0 + v.s1));
            @(negedge CLK);
            o = sample();
            if (o.cw && first_cw < 0) first_cw = c;
            if (o.wen) begin wa.push_back(o.daddr); wd.push_back(o.dstore); end
            if (o.upd) begin upd_cnt++; got_way = o.uway; got_inv = o.uinv; end
            if (!o.busy && idle_at < 0 && c > 0) idle_at = c;
            if (c == v.e_len) chk_obs($sformatf("v%0d idle outputs", n), o, '0);
            @(posedge CLK); #1;
        end
        nw = (v.e_cw >= 0) ? (v.s0 + v.s1 + 2) : 0;
        chk_int($sformatf("v%0d ccwrite first cycle", n), first_cw, v.e_cw);
        chk_int($sformatf("v%0d upd_en count", n), upd_cnt, v.e_upd);
        chk_int($sformatf("v%0d upd way/inv", n), {got_way, got_inv}, {v.e_way, v.e_uinv});
        chk_int($sformatf("v%0d wb word cycles", n), wa.size(), nw);
        for (int k = 0; k < wa.size(); k++) begin
            chk_int($sformatf("v%0d wb addr %0d", n, k), wa[k], (k <= v.s0) ? v.e_a0 : v.e_a0 + 4);
            chk_int($sformatf("v%0d wb data %0d", n, k), wd[k], (k <= v.s0) ? v.e_d0 : v.e_d1);
        end
        chk_int($sformatf("v%0d return to idle", n), idle_at, v.e_len);
    endtask

    task automatic rand_set(input int s);
        for (int w = 0; w < 2; w++) begin
            m_valid[s][w] = ($urandom_range(0, 3) != 0);
            m_dirty[s][w] = $urandom_range(0, 1);
            m_tag[s][w]   = 26'h100 + 26'($urandom_range(0, 3));
            m_d0[s][w]    = $urandom;
            m_d1[s][w]    = $urandom;
        end
    endtask

    // Reference model: derive the expected per-cycle trace of a snoop from
    // the MSI rules, then play it and update the array as the cache would.
    task automatic rand_snoop(input int n);
        logic [25:0] t;
        logic [2:0]  ix, off;
        logic [31:0] a;
        logic        i0, i1, ie, dirty, lk;
        int          s0, s1, hw;
        cyc_t        tr[$];
        cyc_t        c;
        obs_t        e;
        t  = 26'h100 + 26'($urandom_range(0, 3));
        ix = 3'($urandom_range(0, 7));
        off = 3'($urandom_range(0, 7));
        a  = {t, ix, off};
        i0 = $urandom_range(0, 1);
        i1 = ($urandom_range(0, 3) == 0);
        ie = i0 | i1;
        s0 = $urandom_range(0, 2);
        s1 = $urandom_range(0, 2);
        link_valid = $urandom_range(0, 1);
        link_addr  = $urandom_range(0, 1) ? {a[31:3], 3'($urandom_range(0, 7))} : $urandom;
        hw = -1;
        for (int w = 0; w < 2; w++)
            if (hw < 0 && m_valid[ix][w] && m_tag[ix][w] == t) hw = w;
        dirty = (hw >= 0) && m_dirty[ix][hw];
`ifdef SNOOP_LINK_EN
        lk = link_valid && (link_addr[31:3] == a[31:3]);
`else
        lk = 1'b0;
`endif
        c.w = 1; c.inv = i0; c.a = a; c.dw = $urandom_range(0, 1);
        c.e = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tr.push_back(c);
        c.w = 1; c.inv = i1; c.a = $urandom; c.dw = $urandom_range(0, 1);
        c.e = mk(0, 0, 0, 0, 1, ix, 0, 0, 0, (hw >= 0) && !dirty && ie && lk);
        tr.push_back(c);
        if (dirty) begin
            for (int k = 0; k <= s0; k++) begin
                c.w = 1; c.inv = $urandom_range(0, 1); c.a = $urandom; c.dw = (k < s0);
                c.e = mk(1, 1, {a[31:3], 3'b000}, m_d0[ix][hw], 1, ix, 0, 0, 0, 0);
                tr.push_back(c);
            end
            for (int k = 0; k <= s1; k++) begin
                c.w = 1; c.inv = $urandom_range(0, 1); c.a = $urandom; c.dw = (k < s1);
                c.e = mk(1, 1, {a[31:3], 3'b100}, m_d1[ix][hw], 1, ix, 0, 0, 0, 0);
                tr.push_back(c);
            end
        end
        if (dirty || (hw >= 0 && ie)) begin
            c.w = $urandom_range(0, 1); c.inv = $urandom_range(0, 1); c.a = $urandom;
            c.dw = $urandom_range(0, 1);
            c.e = mk(dirty, 0, 0, 0, 1, ix, 1, hw[0], ie, dirty && ie && lk);
            tr.push_back(c);
        end
        c.w = 0; c.inv = $urandom_range(0, 1); c.a = $urandom; c.dw = $urandom_range(0, 1);
        c.e = '0;
        tr.push_back(c);
        foreach (tr[k]) cyc(tr[k].w, tr[k].inv, tr[k].a, tr[k].dw, $sformatf("rand%0d cyc%0d", n, k), tr[k].e);
        if (dirty) begin
            if (ie) m_valid[ix][hw] = 1'b0;
            else    m_dirty[ix][hw] = 1'b0;
        end else if (hw >= 0 && ie) begin
            m_valid[ix][hw] = 1'b0;
        end
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{32'h0000_1040, 1'b0, 0, 0, -1, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2};
        vt[1] = '{32'h0000_1014, 1'b0, 0, 0,  2, 1, 1'b0, 1'b0, 32'h1010, 32'hDEADBEEF, 32'hCAFEF00D, 5};
        vt[2] = '{32'h0000_0458, 1'b1, 0, 0, -1, 1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 3};
        vt[3] = '{32'h0000_0824, 1'b1, 3, 0,  2, 1, 1'b0, 1'b1, 32'h0820, 32'h11111111, 32'h22222222, 8};
        vt[4] = '{32'h0000_041C, 1'b0, 0, 0, -1, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2};
        vt[5] = '{32'h0000_0C28, 1'b1, 0, 0, -1, 1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 3};
        vt[6] = '{32'h0000_0170, 1'b0, 1, 2,  2, 1, 1'b1, 1'b0, 32'h0170, 32'hAAAA0001, 32'hBBBB0002, 8};
        vt[7] = '{32'h0000_01F8, 1'b1, 0, 0, -1, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2};

        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0;
                m_d0[s][w] = '0; m_d1[s][w] = '0;
            end
        m_valid[0][0] = 1; m_dirty[0][0] = 1; m_tag[0][0] = 26'h42;
        m_valid[1][0] = 1; m_tag[1][0] = 26'h80;
        m_valid[2][0] = 1; m_dirty[2][0] = 1; m_tag[2][0] = 26'h40;
        m_d0[2][0] = 32'hDEADBEEF; m_d1[2][0] = 32'hCAFEF00D;
        m_valid[2][1] = 1; m_tag[2][1] = 26'h80;
        m_valid[3][0] = 1; m_tag[3][0] = 26'h10;
        m_valid[3][1] = 1; m_tag[3][1] = 26'h11;
        m_valid[4][0] = 1; m_dirty[4][0] = 1; m_tag[4][0] = 26'h20;
        m_d0[4][0] = 32'h11111111; m_d1[4][0] = 32'h22222222;
        m_valid[5][0] = 1; m_tag[5][0] = 26'h30;
        m_valid[5][1] = 1; m_dirty[5][1] = 1; m_tag[5][1] = 26'h30;
        m_dirty[6][0] = 1; m_tag[6][0] = 26'h5;
        m_valid[6][1] = 1; m_dirty[6][1] = 1; m_tag[6][1] = 26'h5;
        m_d0[6][1] = 32'hAAAA0001; m_d1[6][1] = 32'hBBBB0002;
        m_tag[7][0] = 26'h7; m_dirty[7][0] = 1;

        nRST = 0; ccwait = 0; ccinv = 0; ccsnoopaddr = '0; dwait = 0;
        link_valid = 0; link_addr = '0;
        #12;
        chk_obs("reset outputs", sample(), '0);
        #10 nRST = 1;
        @(posedge CLK); #1;
        cyc(0, 0, 32'h0, 0, "post reset idle", '0);

        for (int n = 0; n < 8; n++) run_vec(n, vt[n]);

        // Abort in WB1: no update, ccwrite dropped, write-back discarded.
        cyc(1, 0, 32'h1010, 0, "abwb1 idle",   mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc(1, 0, 32'h1010, 0, "abwb1 lookup", mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        cyc(1, 0, 32'h1010, 0, "abwb1 wb0",    mk(1, 1, 32'h1010, 32'hDEADBEEF, 1, 2, 0, 0, 0, 0));
        cyc(0, 0, 32'h1010, 0, "abwb1 wb1",    mk(1, 1, 32'h1014, 32'hCAFEF00D, 1, 2, 0, 0, 0, 0));
        cyc(0, 0, 32'h1010, 0, "abwb1 after",  '0);
        cyc(0, 0, 32'h1010, 0, "abwb1 quiet",  '0);

        // Abort in LOOKUP on a dirty hit.
        cyc(1, 1, 32'h1010, 0, "ablk idle",   mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc(0, 1, 32'h1010, 0, "ablk lookup", mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        cyc(0, 0, 32'h1010, 0, "ablk after",  '0);

        // Asynchronous reset while in WB0 with dwait held.
        cyc(1, 0, 32'h1010, 1, "rst idle",   mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc(1, 0, 32'h1010, 1, "rst lookup", mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        ccwait = 1; dwait = 1;
        #2;
        chk_obs("rst wb0 before", sample(), mk(1, 1, 32'h1010, 32'hDEADBEEF, 1, 2, 0, 0, 0, 0));
        nRST = 0; ccwait = 0;
        #1;
        chk_obs("rst async clear", sample(), '0);
        @(posedge CLK); #1;
        chk_obs("rst held", sample(), '0);
        #3 nRST = 1;
        @(posedge CLK); #1;
        cyc(0, 0, 32'h1010, 0, "rst after", '0);

        // Back-to-back: new request accepted in the IDLE cycle after UPDATE.
        cyc(1, 1, 32'h0458, 0, "b2b idle",    mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc(1, 1, 32'h0458, 0, "b2b lookup",  mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
        cyc(1, 1, 32'h0458, 0, "b2b update",  mk(0, 0, 0, 0, 1, 3, 1, 1, 1, 0));
        cyc(1, 0, 32'h01F8, 0, "b2b idle2",   mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc(1, 0, 32'h01F8, 0, "b2b lookup2", mk(0, 0, 0, 0, 1, 7, 0, 0, 0, 0));
        cyc(0, 0, 32'h01F8, 0, "b2b end",     '0);

`ifdef SNOOP_LINK_EN
        link_valid = 1; link_addr = 32'h2008;
        cyc(1, 1, 32'h200C, 0, "link hit idle",   mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc(1, 1, 32'h200C, 0, "link hit lookup", mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        cyc(1, 1, 32'h200C, 0, "link hit update", mk(0, 0, 0, 0, 1, 1, 1, 0, 1, 0));
        cyc(0, 0, 32'h200C, 0, "link hit end",    '0);
        cyc(1, 1, 32'h2010, 0, "link miss idle",   mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc(1, 1, 32'h2010, 0, "link miss lookup", mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        cyc(1, 1, 32'h2010, 0, "link miss update", mk(0, 0, 0, 0, 1, 2, 1, 1, 1, 0));
        cyc(0, 0, 32'h2010, 0, "link miss end",    '0);
        link_valid = 0;
`endif

        for (int s = 0; s < 8; s++) rand_set(s);
        for (int n = 0; n < 150; n++) begin
            if (n % 8 == 0) rand_set($urandom_range(0, 7));
            rand_snoop(n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
